sr_excitation_driver: RTL and testbench

- Drives the S/R inputs of an SR flip-flop (such as the `srt` SR-from-T block) from a stream of target Q values.
- This is the inverse of the SR characteristic equation: for each accepted target bit, the block applies the excitation-table input, waits for settling, and reads back Q/Q_bar.
- It flags any mismatch and guarantees the forbidden input S=R=1 is never driven.
- Sits between a test/sequence source and the flop under control.

---
 rtl/sr_pkg.sv | 19 +
 rtl/sr_exc_enc.sv | 24 ++
 rtl/sr_excitation_driver.sv | 119 +++++++++++
 tb/tb_sr_excitation_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared types and constants for the SR excitation driver
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } sr_state_e;

  // Excitation values are ordered {S,R}.
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_RST  = 2'b01;

  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_CNT_W = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/sr_exc_enc.sv
// rtl/sr_exc_enc.sv - SR excitation-table encoder (target, q) -> {S,R}
module sr_exc_enc
  import sr_pkg::*;
(
  input  logic       tgt_i,
  input  logic       q_i,
  output logic [1:0] sr_o
);

  logic [1:0] exc;

  always_comb begin
    exc = EXC_HOLD;
    if (tgt_i && !q_i) begin
      exc = EXC_SET;
    end else if (!tgt_i && q_i) begin
      exc = EXC_RST;
    end
  end

  // Structural guard: R is forced low whenever S is high, so 2'b11 cannot escape.
  assign sr_o = {exc[1], exc[0] & ~exc[1]};

endmodule

// File: rtl/sr_excitation_driver.sv
// rtl/sr_excitation_driver.sv - drives an SR flop from a target-Q stream and verifies the result
module sr_excitation_driver
  import sr_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tgt_valid,
  input  logic                 tgt_bit,
  output logic                 tgt_ready,
  output logic                 S,
  output logic                 R,
  input  logic                 Q,
  input  logic                 Q_bar,
  input  logic                 clr_err,
  output logic                 done,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
    SETTLE_CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  sr_state_e             state_q, state_d;
  logic                  tgt_q, tgt_d;
  logic [1:0]            sr_q, sr_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  mism_q, mism_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic [1:0]            enc_sr;
  logic                  fail;

  // Encoded from the live bit and Q so the excitation is registered on the accept edge.
  sr_exc_enc u_enc (
    .tgt_i (tgt_bit),
    .q_i   (Q),
    .sr_o  (enc_sr)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    sr_d    = EXC_HOLD;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    mism_d  = 1'b0;
    err_d   = err_q;
    fail    = (Q != tgt_q) || (Q_bar == Q);
    case (state_q)
      IDLE: begin
        if (tgt_valid && ready_q) begin
          tgt_d   = tgt_bit;
          sr_d    = enc_sr;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = SETTLE_LOAD;
        state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK: begin
        done_d  = 1'b1;
        mism_d  = fail;
        state_d = IDLE;
        if (fail && (err_q != '1)) begin
          err_d = err_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_err) begin
      err_d = '0;
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      sr_q    <= EXC_HOLD;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      mism_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      mism_q  <= mism_d;
      err_q   <= err_d;
    end
  end

  assign tgt_ready = ready_q;
  assign S         = sr_q[1];
  assign R         = sr_q[0];
  assign done      = done_q;
  assign mismatch  = mism_q;
  assign err_count = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sr_excitation_driver.sv
// tb/tb_sr_excitation_driver.sv - scoreboard bench over three driver configurations
module tb_sr_excitation_driver;

  localparam int SC_OF  [3] = '{1, 0, 15};
  localparam int MAX_OF [3] = '{255, 3, 255};
  localparam int SAT_SEQ[5] = '{1, 2, 3, 3, 3};

  typedef struct {
    int   due;
    logic mism;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] tv = '0, tb = '0, clr = '0, stuck = '0, qeq = '0;
  logic [2:0] tr, S, R, done, mism, busy, qm, qb;
  logic [2:0] fq = '0;
  logic [7:0] ec0, ec2;
  logic [1:0] ec1;
  logic [7:0] ec [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb [3][$];
  int   drive_due [3] = '{-1, -1, -1};
  logic [1:0] exp_exc [3];
  int   cnt_m [3] = '{0, 0, 0};
  logic [2:0] clr_prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_excitation_driver #(.SETTLE_CYCLES(1), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .rst(rst_n), .tgt_valid(tv[0]), .tgt_bit(tb[0]), .tgt_ready(tr[0]),
    .S(S[0]), .R(R[0]), .Q(qm[0]), .Q_bar(qb[0]), .clr_err(clr[0]),
    .done(done[0]), .mismatch(mism[0]), .err_count(ec0), .busy(busy[0]));
  sr_excitation_driver #(.SETTLE_CYCLES(0), .ERR_CNT_W(2)) dut1 (
    .clk(clk), .rst(rst_n), .tgt_valid(tv[1]), .tgt_bit(tb[1]), .tgt_ready(tr[1]),
    .S(S[1]), .R(R[1]), .Q(qm[1]), .Q_bar(qb[1]), .clr_err(clr[1]),
    .done(done[1]), .mismatch(mism[1]), .err_count(ec1), .busy(busy[1]));
  sr_excitation_driver #(.SETTLE_CYCLES(15), .ERR_CNT_W(8)) dut2 (
    .clk(clk), .rst(rst_n), .tgt_valid(tv[2]), .tgt_bit(tb[2]), .tgt_ready(tr[2]),
    .S(S[2]), .R(R[2]), .Q(qm[2]), .Q_bar(qb[2]), .clr_err(clr[2]),
    .done(done[2]), .mismatch(mism[2]), .err_count(ec2), .busy(busy[2]));

  always_comb begin
    ec[0] = ec0;
    ec[1] = {6'b0, ec1};
    ec[2] = ec2;
  end

  // Flop under control: ideal SR behaviour, with optional stuck-at-0 Q and Q_bar tied to Q.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (S[k]) fq[k] <= 1'b1;
      else if (R[k]) fq[k] <= 1'b0;
    end
  end

  always_comb begin
    qm = '0;
    qb = '0;
    for (int k = 0; k < 3; k++) begin
      qm[k] = stuck[k] ? 1'b0 : fq[k];
      qb[k] = qeq[k] ? qm[k] : ~qm[k];
    end
  end

  function automatic void chk(input string name, input int k, input logic [7:0] act,
                              input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h at cycle %0d", name, k, act, expv, cyc);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic done_exp, mism_exp, busy_exp, qc;
      logic [1:0] sr_exp, ee;
      exp_t e;
      done_exp = 1'b0;
      mism_exp = 1'b0;
      if (!rst_n) begin
        sb[k].delete();
        drive_due[k] = -1;
        cnt_m[k] = 0;
        clr_prev[k] = 1'b0;
      end else begin
        if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
          done_exp = 1'b1;
          mism_exp = sb[k][0].mism;
          void'(sb[k].pop_front());
        end else if (sb[k].size() > 0 && sb[k][0].due < cyc) begin
          chk("done_timeout", k, 8'(done[k]), 8'd1);
          void'(sb[k].pop_front());
        end
        if (clr_prev[k]) cnt_m[k] = 0;
        else if (done_exp && mism_exp && cnt_m[k] < MAX_OF[k]) cnt_m[k]++;
        clr_prev[k] = clr[k];
      end
      busy_exp = (sb[k].size() > 0);
      sr_exp = (rst_n && cyc == drive_due[k]) ? exp_exc[k] : 2'b00;
      chk("done", k, 8'(done[k]), 8'(done_exp));
      chk("mismatch", k, 8'(mism[k]), 8'(mism_exp));
      chk("err_count", k, ec[k], 8'(cnt_m[k]));
      chk("sr", k, 8'({S[k], R[k]}), 8'(sr_exp));
      chk("busy", k, 8'(busy[k]), 8'(busy_exp));
      if (rst_n && tv[k] && tr[k]) begin
        chk("ready_while_busy", k, 8'(tr[k]), 8'(!busy_exp));
        if (tb[k] == qm[k]) ee = 2'b00;
        else if (tb[k]) ee = 2'b10;
        else ee = 2'b01;
        qc = stuck[k] ? 1'b0 : tb[k];
        e.due = cyc + SC_OF[k] + 3;
        e.mism = (qc != tb[k]) || qeq[k];
        sb[k].push_back(e);
        drive_due[k] = cyc + 1;
        exp_exc[k] = ee;
      end
    end
  end

  task automatic accept_tgt(input int k, input logic b);
    int n = 0;
    tv[k] = 1'b1;
    tb[k] = b;
    while (1) begin
      @(negedge clk);
      if (tr[k]) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", k, 8'(tr[k]), 8'd1);
        break;
      end
    end
    @(posedge clk);
    #1 tv[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input bit rc);
    int n = 0;
    while (sb[k].size() != 0 && n < 200) begin
      clr[k] = rc ? ($urandom_range(0, 5) == 0) : 1'b0;
      @(posedge clk);
      #1 n++;
    end
    clr[k] = 1'b0;
    if (sb[k].size() != 0) chk("complete_timeout", k, 8'(sb[k].size()), 8'd0);
  endtask

  task automatic send(input int k, input logic b, input bit rc);
    accept_tgt(k, b);
    wait_done(k, rc);
  endtask

  task automatic clr_pulse(input int k);
    clr[k] = 1'b1;
    @(posedge clk);
    #1 clr[k] = 1'b0;
  endtask

  initial begin
    // Reset release with a target already offered
    tv[0] = 1'b1;
    tb[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready_in_reset", 0, 8'(tr[0]), 8'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_before_edge", 0, 8'(tr[0]), 8'd0);
    @(posedge clk);
    #1 chk("ready_after_release", 0, 8'(tr[0]), 8'd1);
    @(posedge clk);
    #1 tv[0] = 1'b0;
    chk("busy_first_accept", 0, 8'(busy[0]), 8'd1);
    wait_done(0, 1'b0);

    // Closed loop: remaining targets 1,0,0,1 then random traffic with random clears
    send(0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0);
    chk("closed_loop_errs", 0, ec[0], 8'd0);
    for (int i = 0; i < 20; i++) send(0, 1'($urandom_range(0, 1)), 1'b1);

    // Q stuck at 0
    clr_pulse(0);
    stuck[0] = 1'b1;
    send(0, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    stuck[0] = 1'b0;
    chk("stuck_errs", 0, ec[0], 8'd2);

    // Q_bar equal to Q with target 0 and Q=0
    send(0, 1'b0, 1'b0);
    qeq[0] = 1'b1;
    send(0, 1'b0, 1'b0);
    qeq[0] = 1'b0;
    chk("qbar_eq_errs", 0, ec[0], 8'd3);

    // Two-bit counter saturation, then clear coinciding with a failure
    qeq[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1, 1'($urandom_range(0, 1)), 1'b0);
      chk("sat_seq", 1, ec[1], 8'(SAT_SEQ[i]));
    end
    accept_tgt(1, 1'b1);
    repeat (SC_OF[1] + 1) @(posedge clk);
    #1 clr[1] = 1'b1;
    @(posedge clk);
    #1 clr[1] = 1'b0;
    wait_done(1, 1'b0);
    chk("clr_wins", 1, ec[1], 8'd0);
    qeq[1] = 1'b0;
    for (int i = 0; i < 10; i++) send(1, 1'($urandom_range(0, 1)), 1'b1);

    // Long settle, then asynchronous reset during DRIVE of a SET
    for (int i = 0; i < 4; i++) send(2, 1'($urandom_range(0, 1)), 1'b0);
    send(2, 1'b0, 1'b0);
    accept_tgt(2, 1'b1);
    chk("drive_set_S", 2, 8'(S[2]), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("async_S_drop", 2, 8'(S[2]), 8'd0);
    chk("async_busy", 2, 8'(busy[2]), 8'd0);
    chk("async_ready", 2, 8'(tr[2]), 8'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1 send(2, 1'b1, 1'b0);
    send(2, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
